// File: rtl/rnn_pkg.sv
// Shared definitions for the denoise RNN layer sequencer: state encoding,
// layer index map and the per-state awaited-layer lookup.
package rnn_pkg;

    localparam int NUM_LAYERS = 6;

    localparam int L_DENSE1 = 0;
    localparam int L_GRU1   = 1;
    localparam int L_DENSE2 = 2;
    localparam int L_GRU2   = 3;
    localparam int L_GRU3   = 4;
    localparam int L_DENSE3 = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D1,
        ST_G1,
        ST_G2,
        ST_G3,
        ST_D3,
        ST_WAIT,
        ST_OUT
    } seq_state_t;

    // Layer whose done pulse moves the chain forward; S_WAIT reports dense2.
    function automatic logic [2:0] awaited_layer(input seq_state_t s);
        logic [2:0] idx;
        case (s)
            ST_D1:   idx = 3'(L_DENSE1);
            ST_G1:   idx = 3'(L_GRU1);
            ST_G2:   idx = 3'(L_GRU2);
            ST_G3:   idx = 3'(L_GRU3);
            ST_D3:   idx = 3'(L_DENSE3);
            default: idx = 3'(L_DENSE2);
        endcase
        return idx;
    endfunction

    function automatic logic awaits_engine(input seq_state_t s);
        return (s == ST_D1) || (s == ST_G1) || (s == ST_G2) ||
               (s == ST_G3) || (s == ST_D3);
    endfunction

endpackage

// File: rtl/rnn_seq_watchdog.sv
// Per-state cycle watchdog: restarts on every state entry and flags the
// cycle in which the TIMEOUT_CYC-th cycle of the current state is spent.
module rnn_seq_watchdog #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int TIMEOUT_W   = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic active,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_W-1:0] count_reg;
    logic [TIMEOUT_W-1:0] count_cur;

    // count_cur is the number of cycles already spent in the current state
    assign count_cur = restart ? '0 : count_reg;
    assign expired   = active && (count_cur == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (active) begin
            count_reg <= count_cur + TIMEOUT_W'(1);
        end
    end

endmodule

// File: rtl/rnn_layer_sequencer.sv
// Frame scheduler for the six denoise RNN layer engines. Optional per-state
// watchdog is built when RNN_SEQ_TIMEOUT_EN is defined.
module rnn_layer_sequencer
    import rnn_pkg::*;
#(
    parameter int FRAME_CNT_W = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int TIMEOUT_W   = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    input  logic                   state_clear,
    output logic                   feat_load,
    output logic [NUM_LAYERS-1:0]  layer_start,
    input  logic [NUM_LAYERS-1:0]  layer_done,
    output logic                   gru_state_clr,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   result_err,
    output logic                   err_unexp,
    output logic                   err_timeout,
    output logic [2:0]             err_layer,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   busy
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TIMEOUT_W)) begin : g_bad_timeout_cfg
        $error("TIMEOUT_CYC must lie in 1 .. 2**TIMEOUT_W-1");
    end

    seq_state_t             state_reg, state_next;
    logic                   entry_reg;
    logic                   clr_q_reg, clr_q_next;
    logic                   d2_pend_reg, d2_pend_next;
    logic                   err_unexp_reg;
    logic [FRAME_CNT_W-1:0] frame_cnt_reg;
    logic [NUM_LAYERS-1:0]  unexp_vec;
    logic [2:0]             await_idx;
    logic                   await_any;
    logic                   complete;

    assign await_idx = awaited_layer(state_reg);
    assign await_any = awaits_engine(state_reg);
    assign complete  = (state_reg == ST_OUT) && result_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_unexp
            assign unexp_vec[gi] = layer_done[gi]
                && !(await_any && (await_idx == 3'(gi)))
                && !((gi == L_DENSE2) && d2_pend_reg);
        end
    endgenerate

`ifdef RNN_SEQ_TIMEOUT_EN
    logic       wd_active;
    logic       timeout_hit;
    logic       timeout_jump;
    logic       err_timeout_reg;
    logic [2:0] err_layer_reg;
    logic       result_err_reg;

    assign wd_active = (state_reg == ST_D1) || (state_reg == ST_G1) ||
                       (state_reg == ST_G2) || (state_reg == ST_G3) ||
                       (state_reg == ST_D3) || (state_reg == ST_WAIT);

    rnn_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TIMEOUT_W   (TIMEOUT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .restart (entry_reg),
        .active  (wd_active),
        .expired (timeout_hit)
    );
`endif

    always_comb begin
        state_next   = state_reg;
        layer_start  = '0;
        d2_pend_next = d2_pend_reg;
        clr_q_next   = clr_q_reg;
`ifdef RNN_SEQ_TIMEOUT_EN
        timeout_jump = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (frame_valid) begin
                    state_next = ST_D1;
                    clr_q_next = state_clear;
                end
            end
            ST_D1: begin
                layer_start[L_DENSE1] = entry_reg;
                if (layer_done[L_DENSE1]) state_next = ST_G1;
            end
            ST_G1: begin
                layer_start[L_GRU1] = entry_reg;
                if (layer_done[L_GRU1]) begin
                    state_next   = ST_G2;
                    d2_pend_next = 1'b1;
                end
            end
            ST_G2: begin
                layer_start[L_DENSE2] = entry_reg;
                layer_start[L_GRU2]   = entry_reg;
                if (layer_done[L_GRU2]) state_next = ST_G3;
            end
            ST_G3: begin
                layer_start[L_GRU3] = entry_reg;
                if (layer_done[L_GRU3]) state_next = ST_D3;
            end
            ST_D3: begin
                layer_start[L_DENSE3] = entry_reg;
                if (layer_done[L_DENSE3]) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!d2_pend_reg) state_next = ST_OUT;
            end
            ST_OUT: begin
                if (result_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // dense2 runs alongside the gru2 -> gru3 -> dense3 chain
        if (layer_done[L_DENSE2] &&
            ((state_reg == ST_G2) || (state_reg == ST_G3) ||
             (state_reg == ST_D3) || (state_reg == ST_WAIT))) begin
            d2_pend_next = 1'b0;
        end

`ifdef RNN_SEQ_TIMEOUT_EN
        // A done pulse in the expiry cycle still wins over the abort
        if (timeout_hit && (state_next == state_reg)) begin
            timeout_jump = 1'b1;
            state_next   = ST_OUT;
            d2_pend_next = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            entry_reg     <= 1'b0;
            clr_q_reg     <= 1'b0;
            d2_pend_reg   <= 1'b0;
            err_unexp_reg <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            entry_reg   <= (state_next != state_reg);
            clr_q_reg   <= clr_q_next;
            d2_pend_reg <= d2_pend_next;
            if ((state_reg != ST_IDLE) && (|unexp_vec)) begin
                err_unexp_reg <= 1'b1;
            end
            if (complete) begin
                frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
            end
        end
    end

`ifdef RNN_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout_reg <= 1'b0;
            err_layer_reg   <= '0;
            result_err_reg  <= 1'b0;
        end else if (timeout_jump) begin
            err_timeout_reg <= 1'b1;
            err_layer_reg   <= await_idx;
            result_err_reg  <= 1'b1;
        end else if (complete) begin
            result_err_reg  <= 1'b0;
        end
    end

    assign err_timeout = err_timeout_reg;
    assign err_layer   = err_layer_reg;
    assign result_err  = result_err_reg && (state_reg == ST_OUT);
`else
    assign err_timeout = 1'b0;
    assign err_layer   = '0;
    assign result_err  = 1'b0;
`endif

    assign frame_ready   = (state_reg == ST_IDLE);
    assign feat_load     = (state_reg == ST_IDLE) && frame_valid;
    assign result_valid  = (state_reg == ST_OUT);
    assign busy          = (state_reg != ST_IDLE);
    assign err_unexp     = err_unexp_reg;
    assign frame_cnt     = frame_cnt_reg;
    assign gru_state_clr = clr_q_reg && (layer_start[L_GRU1] |
                                         layer_start[L_GRU2] |
                                         layer_start[L_GRU3]);

endmodule

// File: tb/tb_rnn_layer_sequencer.sv
// Directed bench for rnn_layer_sequencer: a per-cycle vector table for the
// nominal frame plus hand sequences for dense2 overlap, errors and reset.
module tb_rnn_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_valid;
    logic        frame_ready;
    logic        state_clear;
    logic        feat_load;
    logic [5:0]  layer_start;
    logic [5:0]  layer_done;
    logic        gru_state_clr;
    logic        result_valid;
    logic        result_ready;
    logic        result_err;
    logic        err_unexp;
    logic        err_timeout;
    logic [2:0]  err_layer;
    logic [15:0] frame_cnt;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rnn_layer_sequencer #(
        .FRAME_CNT_W (16),
        .TIMEOUT_CYC (16),
        .TIMEOUT_W   (13)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .state_clear   (state_clear),
        .feat_load     (feat_load),
        .layer_start   (layer_start),
        .layer_done    (layer_done),
        .gru_state_clr (gru_state_clr),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_err    (result_err),
        .err_unexp     (err_unexp),
        .err_timeout   (err_timeout),
        .err_layer     (err_layer),
        .frame_cnt     (frame_cnt),
        .busy          (busy)
    );

    typedef struct {
        logic        fv;
        logic        sc;
        logic [5:0]  done;
        logic        rr;
        logic [5:0]  start;
        logic        fl;
        logic        fr;
        logic        rv;
        logic        gsc;
        logic        busy;
        logic [15:0] fcnt;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One new cycle: drive inputs just after the edge, return at the falling edge
    task automatic drive(input logic fv, input logic sc, input logic [5:0] d,
                         input logic rr, input logic rs);
        @(posedge clk);
        #1;
        frame_valid  = fv;
        state_clear  = sc;
        layer_done   = d;
        result_ready = rr;
        rst          = rs;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst          = 1'b1;
        frame_valid  = 1'b0;
        state_clear  = 1'b0;
        layer_done   = '0;
        result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state",
            {layer_start, feat_load, frame_ready, result_valid, gru_state_clr,
             busy, err_unexp, result_err, err_timeout, err_layer, frame_cnt},
            {6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0});

        // Nominal frame, state_clear=1: engines answer 3 cycles after start, dense2 after 2
        for (int i = 0; i < 24; i++) begin
            vecs[i] = '{fv: 1'b0, sc: 1'b0, done: 6'h00, rr: 1'b0, start: 6'h00,
                        fl: 1'b0, fr: 1'b0, rv: 1'b0, gsc: 1'b0, busy: 1'b1, fcnt: 16'd0};
        end
        vecs[0].fv = 1'b1;  vecs[0].sc = 1'b1;  vecs[0].fl = 1'b1;
        vecs[0].fr = 1'b1;  vecs[0].busy = 1'b0;
        vecs[1].start  = 6'b000001;
        vecs[4].done   = 6'b000001;
        vecs[5].start  = 6'b000010;  vecs[5].gsc = 1'b1;
        vecs[8].done   = 6'b000010;
        vecs[9].start  = 6'b001100;  vecs[9].gsc = 1'b1;
        vecs[11].done  = 6'b000100;
        vecs[12].done  = 6'b001000;
        vecs[13].start = 6'b010000;  vecs[13].gsc = 1'b1;
        vecs[16].done  = 6'b010000;
        vecs[17].start = 6'b100000;
        vecs[20].done  = 6'b100000;
        vecs[22].rv = 1'b1;  vecs[22].rr = 1'b1;
        vecs[23].fr = 1'b1;  vecs[23].busy = 1'b0;  vecs[23].fcnt = 16'd1;

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].fv, vecs[i].sc, vecs[i].done, vecs[i].rr, 1'b0);
            chk($sformatf("nominal_c%0d", i),
                {layer_start, feat_load, frame_ready, result_valid, gru_state_clr,
                 busy, err_unexp, result_err, frame_cnt},
                {vecs[i].start, vecs[i].fl, vecs[i].fr, vecs[i].rv, vecs[i].gsc,
                 vecs[i].busy, 1'b0, 1'b0, vecs[i].fcnt});
            $display("nominal cycle %0d: start=%b rv=%b gsc=%b fcnt=%0d",
                     i, layer_start, result_valid, gru_state_clr, frame_cnt);
        end

        // Frame 2: no clear, done coincident with start, dense2 20 cycles after dense3
        drive(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
        chk("s2_accept", {feat_load, frame_ready}, 2'b11);
        drive(1'b0, 1'b0, 6'h01, 1'b0, 1'b0);
        chk("s2_start_d1", {layer_start, gru_state_clr}, {6'h01, 1'b0});
        drive(1'b0, 1'b0, 6'h02, 1'b0, 1'b0);
        chk("s2_start_g1", {layer_start, gru_state_clr}, {6'h02, 1'b0});
        drive(1'b0, 1'b0, 6'h08, 1'b0, 1'b0);
        chk("s2_start_g2", {layer_start, gru_state_clr}, {6'h0C, 1'b0});
        drive(1'b0, 1'b0, 6'h10, 1'b0, 1'b0);
        chk("s2_start_g3", {layer_start, gru_state_clr}, {6'h10, 1'b0});
        drive(1'b0, 1'b0, 6'h20, 1'b0, 1'b0);
        chk("s2_start_d3", layer_start, 6'h20);
        for (int k = 0; k < 19; k++) begin
            drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
            chk($sformatf("s2_wait_%0d", k), {layer_start, result_valid, busy}, {6'h00, 2'b01});
        end
        drive(1'b0, 1'b0, 6'h04, 1'b0, 1'b0);
        chk("s2_d2_done", result_valid, 1'b0);
        drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        chk("s2_d2_plus1", result_valid, 1'b0);
        drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
        chk("s2_d2_plus2", {result_valid, err_unexp, frame_cnt}, {2'b10, 16'd1});
        drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        chk("s2_done", {frame_ready, busy, frame_cnt}, {2'b10, 16'd2});
        $display("slow dense2 frame: frame_cnt=%0d err_unexp=%b", frame_cnt, err_unexp);

        // Frame 3: spurious gru3 done in S_G1, dense2 and gru2 done together
        drive(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 6'h01, 1'b0, 1'b0);
        chk("s3_start_d1", layer_start, 6'h01);
        drive(1'b0, 1'b0, 6'h10, 1'b0, 1'b0);
        chk("s3_start_g1", {layer_start, err_unexp}, {6'h02, 1'b0});
        drive(1'b0, 1'b0, 6'h02, 1'b0, 1'b0);
        chk("s3_unexp_set", {layer_start, err_unexp}, {6'h00, 1'b1});
        drive(1'b0, 1'b0, 6'h0C, 1'b0, 1'b0);
        chk("s3_start_g2", layer_start, 6'h0C);
        drive(1'b0, 1'b0, 6'h10, 1'b0, 1'b0);
        chk("s3_start_g3", {layer_start, err_unexp}, {6'h10, 1'b1});
        drive(1'b0, 1'b0, 6'h20, 1'b0, 1'b0);
        chk("s3_start_d3", layer_start, 6'h20);
        drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        chk("s3_wait", {result_valid, busy}, 2'b01);
        drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
        chk("s3_result", {result_valid, err_unexp}, 2'b11);
        drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        chk("s3_done", {err_unexp, frame_cnt}, {1'b1, 16'd3});
        $display("spurious done frame: err_unexp=%b frame_cnt=%0d", err_unexp, frame_cnt);

        // Frame 4: reset in S_G3, then a stale gru3 done
        drive(1'b1, 1'b1, 6'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 6'h01, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 6'h02, 1'b0, 1'b0);
        chk("s4_g1_clr", {layer_start, gru_state_clr}, {6'h02, 1'b1});
        drive(1'b0, 1'b0, 6'h0C, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
        chk("s4_in_g3", {layer_start, gru_state_clr}, {6'h10, 1'b1});
        drive(1'b0, 1'b0, 6'h10, 1'b0, 1'b0);
        chk("s4_after_rst", {layer_start, busy, frame_ready, err_unexp, gru_state_clr, frame_cnt},
            {6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0});
        drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        chk("s4_stale_done", {layer_start, busy, err_unexp}, {6'h00, 1'b0, 1'b0});
        $display("reset mid-frame: busy=%b err_unexp=%b frame_cnt=%0d", busy, err_unexp, frame_cnt);

`ifdef RNN_SEQ_TIMEOUT_EN
        // gru2 never answers: abort to S_OUT after 16 cycles in S_G2
        drive(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 6'h01, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 6'h02, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        chk("s5_start_g2", layer_start, 6'h0C);
        for (int k = 1; k < 16; k++) begin
            drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
            chk($sformatf("s5_g2_hold_%0d", k), {result_valid, err_timeout}, 2'b00);
        end
        drive(1'b0, 1'b0, 6'h00, 1'b1, 1'b0);
        chk("s5_timeout", {result_valid, result_err, err_timeout, err_layer}, {3'b111, 3'd3});
        drive(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
        chk("s5_done", {busy, result_err, err_timeout, frame_cnt}, {3'b001, 16'd1});
        $display("timeout frame: err_timeout=%b err_layer=%0d", err_timeout, err_layer);
`else
        chk("no_watchdog", {err_timeout, err_layer, result_err}, 5'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
